// File: rtl/riscv_pkg.sv
// Shared integer-pipe types.
//   alu_op_t  : opcode set understood by the 64-bit ALU
//   alu_req_t : one ALU operation (opcode plus both operands), used to carry the
//               selected requester's operation from the arbiter mux to the ALU
package riscv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    typedef struct packed {
        alu_op_t     op;
        logic [63:0] a;
        logic [63:0] b;
    } alu_req_t;

endpackage

// File: rtl/alu.sv
// 64-bit combinational integer ALU.
// Ports:
//   op_i     : operation select
//   a_i, b_i : operands (shift amount is b_i[5:0])
//   result_o : result; any opcode outside alu_op_t returns 0
module alu
    import riscv_pkg::*;
(
    input  alu_op_t     op_i,
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    output logic [63:0] result_o
);

    logic [5:0] shamt;

    assign shamt = b_i[5:0];

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SLT:  result_o = {63'd0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: result_o = {63'd0, a_i < b_i};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SRL:  result_o = a_i >> shamt;
            ALU_SRA:  result_o = $signed(a_i) >>> shamt;
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req_i      : request vector
//   ptr_i      : highest-priority index for this cycle
//   en_i       : when low, no grant is issued
//   grant_o    : one-hot grant (or zero)
//   grant_id_o : encoded index of the grant (0 when there is none)
// The first requesting index at or above ptr_i wins, wrapping past NUM_REQ-1.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_id_o
);

    int              idx;
    logic [ID_W-1:0] sel;
    logic            found;

    always_comb begin
        grant_o    = '0;
        grant_id_o = '0;
        found      = 1'b0;
        idx        = 0;
        sel        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // ptr_i is always below NUM_REQ, so a single subtract wraps it
            idx = int'(ptr_i) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = ID_W'(idx);
            if (en_i && !found && req_i[sel]) begin
                found        = 1'b1;
                grant_o[sel] = 1'b1;
                grant_id_o   = sel;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one 64-bit ALU among NUM_REQ requesters. One request per cycle is
// picked round-robin, executed, and its result is captured in a single output
// register together with the requester index.
// Ports:
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   req_valid_i/req_ready_o : per-requester handshake (ready is one-hot or zero)
//   req_op_i/a_i/b_i        : per-requester operation and operands
//   resp_valid_o/ready_i    : output register handshake
//   resp_result_o           : registered ALU result
//   resp_id_o               : index of the requester that produced the result
module alu_share_arbiter
    import riscv_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_valid_i,
    output logic [NUM_REQ-1:0] req_ready_o,
    input  alu_op_t            req_op_i [NUM_REQ],
    input  logic [63:0]        req_a_i  [NUM_REQ],
    input  logic [63:0]        req_b_i  [NUM_REQ],
    output logic               resp_valid_o,
    input  logic               resp_ready_i,
    output logic [63:0]        resp_result_o,
    output logic [ID_W-1:0]    resp_id_o
);

    logic               resp_valid_q, resp_valid_d;
    logic [63:0]        resp_result_q, resp_result_d;
    logic [ID_W-1:0]    resp_id_q, resp_id_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;

    logic               can_accept;
    logic               arb_en;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               handshake;
    alu_req_t           sel_req;
    logic [63:0]        alu_result;

    // Only the valid flag and the consumer's ready decide acceptance, so the
    // ready path never sees the stored result. Ready is held low during reset.
    assign can_accept = !resp_valid_q || resp_ready_i;
    assign arb_en     = can_accept && !rst_i;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i      (req_valid_i),
        .ptr_i      (ptr_q),
        .en_i       (arb_en),
        .grant_o    (grant),
        .grant_id_o (grant_id)
    );

    assign req_ready_o = grant;
    assign handshake   = |(req_valid_i & grant);

    // One-hot AND-OR select of the winning request
    always_comb begin
        sel_req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_req.op = req_op_i[i];
                sel_req.a  = req_a_i[i];
                sel_req.b  = req_b_i[i];
            end
        end
    end

    alu u_alu (
        .op_i     (sel_req.op),
        .a_i      (sel_req.a),
        .b_i      (sel_req.b),
        .result_o (alu_result)
    );

    always_comb begin
        resp_valid_d  = resp_valid_q;
        resp_result_d = resp_result_q;
        resp_id_d     = resp_id_q;
        ptr_d         = ptr_q;
        if (handshake) begin
            resp_valid_d  = 1'b1;
            resp_result_d = alu_result;
            resp_id_d     = grant_id;
            ptr_d         = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end else if (resp_ready_i) begin
            // drain without refill; result and id are left as they were
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
            resp_id_q     <= '0;
            ptr_q         <= '0;
        end else begin
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_id_q     <= resp_id_d;
            ptr_q         <= ptr_d;
        end
    end

    assign resp_valid_o  = resp_valid_q;
    assign resp_result_o = resp_result_q;
    assign resp_id_o     = resp_id_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
    import riscv_pkg::*;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    logic rst_i;

    // two-requester instance
    logic [1:0]  v2, r2;
    alu_op_t     op2 [2];
    logic [63:0] a2 [2], b2 [2];
    logic        rv2, rr2;
    logic [63:0] res2;
    logic [0:0]  id2;

    // four-requester instance
    logic [3:0]  v4, r4;
    alu_op_t     op4 [4];
    logic [63:0] a4 [4], b4 [4];
    logic        rv4, rr4;
    logic [63:0] res4;
    logic [1:0]  id4;

    int n_tests = 0;
    int n_fail  = 0;

    alu_share_arbiter #(.NUM_REQ(2)) dut2 (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(v2), .req_ready_o(r2),
        .req_op_i(op2), .req_a_i(a2), .req_b_i(b2),
        .resp_valid_o(rv2), .resp_ready_i(rr2),
        .resp_result_o(res2), .resp_id_o(id2)
    );

    alu_share_arbiter #(.NUM_REQ(4)) dut4 (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(v4), .req_ready_o(r4),
        .req_op_i(op4), .req_a_i(a4), .req_b_i(b4),
        .resp_valid_o(rv4), .resp_ready_i(rr4),
        .resp_result_o(res4), .resp_id_o(id4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        v2 = '0;
        v4 = '0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    function automatic logic [63:0] alu_ref(alu_op_t op, logic [63:0] a, logic [63:0] b);
        int sh;
        sh = int'(b % 64);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << sh;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return $signed(a) >>> sh;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            ALU_SLTU: return (a < b) ? 64'd1 : 64'd0;
            ALU_XOR:  return a ^ b;
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return 64'd0;
        endcase
    endfunction

    // reference model state for the four-requester instance
    bit          m_valid;
    logic [63:0] m_res;
    int          m_id;
    int          m_ptr;
    int          id_cnt [4];

    initial begin
        rst_i = 1'b1;
        v2 = '0; rr2 = 1'b1; v4 = '0; rr4 = 1'b1;
        for (int i = 0; i < 2; i++) begin op2[i] = ALU_ADD; a2[i] = '0; b2[i] = '0; end
        for (int i = 0; i < 4; i++) begin op4[i] = ALU_ADD; a4[i] = '0; b4[i] = '0; id_cnt[i] = 0; end

        // ready must stay low while reset is held, even with requests pending
        v2 = 2'b11;
        #2;
        check("rst_ready", r2, 2'b00);
        check("rst_valid", rv2, 0);
        check("rst_result", res2, 0);
        check("rst_id", id2, 0);
        do_reset();

        // 1: single ADD after reset
        v2 = 2'b01; op2[0] = ALU_ADD; a2[0] = 64'd5; b2[0] = 64'd7;
        #1 check("t1_ready", r2, 2'b01);
        tick();
        v2 = 2'b00;
        check("t1_valid", rv2, 1);
        check("t1_result", res2, 64'd12);
        check("t1_id", id2, 0);

        // 2: both valid, round robin from 0
        do_reset();
        v2 = 2'b11; rr2 = 1'b1;
        op2[0] = ALU_SUB; a2[0] = 64'd10; b2[0] = 64'd3;
        op2[1] = ALU_SLL; a2[1] = 64'd1;  b2[1] = 64'd63;
        #1 check("t2_ready0", r2, 2'b01);
        tick();
        check("t2_result0", res2, 64'd7);
        check("t2_id0", id2, 0);
        check("t2_ready1", r2, 2'b10);
        tick();
        check("t2_result1", res2, 64'h8000_0000_0000_0000);
        check("t2_id1", id2, 1);
        check("t2_ptr_back", r2, 2'b01);
        tick();
        check("t2_result2", res2, 64'd7);

        // 3: stall three cycles, then drain and refill together
        rr2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t3_stall_ready", r2, 2'b00);
            check("t3_stall_result", res2, 64'd7);
            check("t3_stall_id", id2, 0);
            check("t3_stall_valid", rv2, 1);
            tick();
        end
        rr2 = 1'b1;
        #1 check("t3_refill_ready", r2, 2'b10);
        tick();
        check("t3_refill_valid", rv2, 1);
        check("t3_refill_result", res2, 64'h8000_0000_0000_0000);
        check("t3_refill_id", id2, 1);

        // 5: reset during a stall with an SLT result pending
        v2 = 2'b01; op2[0] = ALU_SLT; a2[0] = '1; b2[0] = 64'd0;
        tick();
        check("t5_slt", res2, 64'd1);
        rr2 = 1'b0;
        tick();
        check("t5_held", res2, 64'd1);
        rst_i = 1'b1;
        #1;
        check("t5_rst_valid", rv2, 0);
        check("t5_rst_ready", r2, 2'b00);
        tick();
        rst_i = 1'b0;
        v2 = 2'b00;
        rr2 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_no_resp", rv2, 0);
        end
        v2 = 2'b11;
        #1 check("t5_ptr0", r2, 2'b01);

        // 6: lone requester 1 is granted repeatedly
        do_reset();
        v2 = 2'b10; op2[1] = ALU_SRA; a2[1] = 64'h8000_0000_0000_0000; b2[1] = 64'd4;
        #1 check("t6_ready", r2, 2'b10);
        tick();
        check("t6_result", res2, 64'hF800_0000_0000_0000);
        check("t6_id", id2, 1);
        check("t6_regrant", r2, 2'b10);
        tick();
        check("t6_id_again", id2, 1);

        // unknown opcode yields a normal response with result 0
        v2 = 2'b01; op2[0] = alu_op_t'(4'hF); a2[0] = 64'd5; b2[0] = 64'd5;
        tick();
        check("unk_valid", rv2, 1);
        check("unk_result", res2, 64'd0);
        check("unk_id", id2, 0);
        v2 = 2'b00;
        tick();
        check("drain_valid", rv2, 0);

        // 4: continuous demand on four ports, 16 handshakes
        do_reset();
        v4 = 4'hF; rr4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op4[i] = ALU_ADD; a4[i] = 64'(i * 100); b4[i] = 64'd1;
        end
        for (int k = 0; k < 16; k++) begin
            #1 check("t4_ready", r4, 64'(1 << (k % 4)));
            tick();
            check("t4_id", id4, 64'(k % 4));
            check("t4_result", res4, 64'((k % 4) * 100 + 1));
            id_cnt[id4]++;
        end
        for (int i = 0; i < 4; i++) check("t4_count", 64'(id_cnt[i]), 64'd4);

        // randomized traffic against the reference model
        do_reset();
        m_valid = 0; m_res = '0; m_id = 0; m_ptr = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            int g;
            bit can;
            v4  = 4'($urandom);
            rr4 = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                op4[i] = alu_op_t'(4'($urandom_range(0, 11)));
                a4[i]  = {$urandom, $urandom};
                b4[i]  = ($urandom_range(0, 1) != 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
            end
            #1;
            can = !m_valid || rr4;
            g = -1;
            if (can) begin
                for (int k = 0; k < 4; k++) begin
                    if (g < 0 && v4[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
                end
            end
            check("rnd_ready", r4, (g >= 0) ? 64'(1 << g) : 64'd0);
            if (g >= 0) begin
                m_valid = 1;
                m_res   = alu_ref(op4[g], a4[g], b4[g]);
                m_id    = g;
                m_ptr   = (g + 1) % 4;
            end else if (rr4) begin
                m_valid = 0;
            end
            tick();
            check("rnd_valid", rv4, m_valid);
            if (m_valid) begin
                check("rnd_result", res4, m_res);
                check("rnd_id", id4, 64'(m_id));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
